win_collision_detector: RTL and testbench
=========================================

# win_collision_detector

Consumes the per-pixel outputs of the bitmap drawers (drawingRequest, HitEdgeCode) for the player, the win object and the walls. Detects pixel overlaps during each VGA frame and reports them once per frame at the next startOfFrame. Also declares a game win after a configurable number of consecutive frames of player/win overlap. Sits between the bitmap layer and the game-control FSM.

## Interface
- WIN_FRAMES, 2: consecutive frames with player/win overlap needed to set gameWon (1..15)
- clk  in  1  pixel clock, same clock as the bitmap drawers
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse from the VGA controller; marks the frame boundary
- playerDrawingRequest  in  1  player bitmap wants this pixel
- playerHitEdgeCode  in  4  player edge code {Left, Top, Right, Bottom}; valid in the same cycle as playerDrawingRequest
- winDrawingRequest  in  1  win bitmap wants this pixel
- wallDrawingRequest  in  1  wall/board layer wants this pixel
- clearWin  in  1  synchronous clear of gameWon and the win counter
- collisionWall  out  1  one-cycle pulse: the previous frame had a player/wall overlap
- collisionWin  out  1  one-cycle pulse: the previous frame had a player/win overlap
- wallEdgeCode  out  4  OR of playerHitEdgeCode over all player/wall overlap pixels of the previous frame; held until the next report
- gameWon  out  1  sticky win flag

## Operation
- All drawer inputs are registered by their sources and arrive mutually aligned, so the block does not delay them.
- States (shared enum):
  - WAIT_SOF: entered on reset. Overlaps are ignored. Goes to ACCUM on the first startOfFrame; no report is made for that frame.
  - ACCUM: accumulate flags. On startOfFrame, go to REPORT.
  - REPORT: one cycle; issue pulses, then go to ACCUM.
- Accumulators, updated in ACCUM and in the REPORT cycle:
  - wallHit |= player & wall.
  - winHit |= player & win.
  - edgeAcc |= playerHitEdgeCode, only when player & wall.
- On the startOfFrame cycle in ACCUM:
  - The frame snapshot is wallHit/winHit/edgeAcc OR'd with the current cycle's overlap terms.
  - The accumulators are then cleared.
- REPORT cycle outputs:
  - collisionWall = snapshot wallHit.
  - collisionWin = snapshot winHit.
  - wallEdgeCode <= snapshot edgeAcc, loaded only if snapshot wallHit = 1; otherwise the previous value is held.
- Overlap in the REPORT cycle is accumulated into the new frame.
- Win counter, width 4, updated at each snapshot:
  - snapshot winHit = 1: increment, saturating at WIN_FRAMES.
  - snapshot winHit = 0: reset to 0.
  - gameWon sets when the counter reaches WIN_FRAMES.
- clearWin:
  - Zeroes the counter and gameWon in the cycle it is sampled.
  - Has priority over a simultaneous set or increment.
  - Does not affect the per-frame accumulators.
- startOfFrame while in REPORT is not possible (minimum frame length is more than 2 cycles) and is ignored.

## Timing
- Reset values: collisionWall = 0, collisionWin = 0, wallEdgeCode = 4'h0, gameWon = 0; counter = 0; state WAIT_SOF; accumulators 0.
- Latency:
  - Pulses and wallEdgeCode are registered and change on the edge after startOfFrame is sampled (1 cycle).
  - gameWon rises in that same cycle.
- Each pulse is exactly 1 cycle wide; at most one pulse of each kind per frame.
- If resetN is asserted mid-frame, partial accumulation is lost and the next report is two frame boundaries later.

## Structure
- collision_pkg holds:
  - state enum {WAIT_SOF, ACCUM, REPORT}
  - edge bit indices EDGE_LEFT = 3, EDGE_TOP = 2, EDGE_RIGHT = 1, EDGE_BOTTOM = 0
  - the edge code width of 4
- Single module; the win counter and sticky flag are small enough to stay inline. No sub-module.

## Test plan
- Reset, then two startOfFrame pulses with no drawing requests -> no pulses, wallEdgeCode = 0, gameWon = 0.
- Frame with 3 player/wall overlap pixels carrying codes 4'h8, 4'h4, 4'h8 -> at the next SOF+1, collisionWall = 1 for 1 cycle and wallEdgeCode = 4'hC. wallEdgeCode holds 4'hC through a following clean frame.
- Overlap in the first frame after reset (state WAIT_SOF) -> no report. The same overlap in the next frame -> collisionWall pulse.
- WIN_FRAMES = 2:
  - Win overlap in frames N and N+1 -> gameWon rises at the SOF ending frame N+1 (plus 1 cycle).
  - Sequence win, miss, win -> gameWon stays 0.
- gameWon = 1, clearWin asserted on the same cycle as a qualifying snapshot -> gameWon = 0 and counter = 0.
- Overlap asserted exactly on the startOfFrame cycle -> counted in the ending frame. Overlap on the REPORT cycle -> reported at the following SOF.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared definitions for the collision/win detection layer: controller states
// and player edge-code bit positions.
package collision_pkg;

  localparam int EDGE_W      = 4;
  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    REPORT   = 2'd2
  } state_t;

endpackage

// File: rtl/win_collision_detector.sv
// Accumulates player/wall and player/win pixel overlaps over a VGA frame and
// reports them once per frame, plus a sticky win flag after consecutive win frames.
module win_collision_detector
  import collision_pkg::*;
#(
  parameter int WIN_FRAMES = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              playerDrawingRequest,
  input  logic [EDGE_W-1:0] playerHitEdgeCode,
  input  logic              winDrawingRequest,
  input  logic              wallDrawingRequest,
  input  logic              clearWin,
  output logic              collisionWall,
  output logic              collisionWin,
  output logic [EDGE_W-1:0] wallEdgeCode,
  output logic              gameWon
);

  localparam logic [3:0] WIN_TARGET = 4'(WIN_FRAMES);

  state_t            state;
  logic              wall_hit;
  logic              win_hit;
  logic [EDGE_W-1:0] edge_acc;
  logic [3:0]        win_cnt;

  logic              wall_now;
  logic              win_now;
  logic [EDGE_W-1:0] edge_now;
  logic              snap_wall;
  logic              snap_win;
  logic [EDGE_W-1:0] snap_edge;
  logic              snapshot;
  logic [3:0]        win_cnt_next;

  // The frame-ending cycle's own overlap belongs to the frame it closes.
  assign wall_now  = playerDrawingRequest & wallDrawingRequest;
  assign win_now   = playerDrawingRequest & winDrawingRequest;
  assign edge_now  = wall_now ? playerHitEdgeCode : '0;
  assign snap_wall = wall_hit | wall_now;
  assign snap_win  = win_hit | win_now;
  assign snap_edge = edge_acc | edge_now;
  assign snapshot  = (state == ACCUM) && startOfFrame;

  always_comb begin
    win_cnt_next = 4'd0;
    if (snap_win) begin
      win_cnt_next = (win_cnt >= WIN_TARGET) ? WIN_TARGET : win_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= WAIT_SOF;
      wall_hit      <= 1'b0;
      win_hit       <= 1'b0;
      edge_acc      <= '0;
      collisionWall <= 1'b0;
      collisionWin  <= 1'b0;
      wallEdgeCode  <= '0;
      win_cnt       <= 4'd0;
      gameWon       <= 1'b0;
    end else begin
      collisionWall <= 1'b0;
      collisionWin  <= 1'b0;

      case (state)
        WAIT_SOF: begin
          if (startOfFrame) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (startOfFrame) begin
            collisionWall <= snap_wall;
            collisionWin  <= snap_win;
            if (snap_wall) begin
              wallEdgeCode <= snap_edge;
            end
            wall_hit <= 1'b0;
            win_hit  <= 1'b0;
            edge_acc <= '0;
            state    <= REPORT;
          end else begin
            wall_hit <= snap_wall;
            win_hit  <= snap_win;
            edge_acc <= snap_edge;
          end
        end
        REPORT: begin
          // A start-of-frame here cannot occur and is deliberately ignored.
          wall_hit <= snap_wall;
          win_hit  <= snap_win;
          edge_acc <= snap_edge;
          state    <= ACCUM;
        end
        default: begin
          state <= WAIT_SOF;
        end
      endcase

      if (clearWin) begin
        win_cnt <= 4'd0;
        gameWon <= 1'b0;
      end else if (snapshot) begin
        win_cnt <= win_cnt_next;
        if (win_cnt_next == WIN_TARGET) begin
          gameWon <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_win_collision_detector.sv
// Self-checking bench: directed frame scenarios plus randomized frames checked
// against a frame-level reference model.
module tb_win_collision_detector;

  localparam int WF = 2;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       playerDrawingRequest = 1'b0;
  logic [3:0] playerHitEdgeCode = 4'h0;
  logic       winDrawingRequest = 1'b0;
  logic       wallDrawingRequest = 1'b0;
  logic       clearWin = 1'b0;
  logic       collisionWall;
  logic       collisionWin;
  logic [3:0] wallEdgeCode;
  logic       gameWon;

  int tests = 0;
  int fails = 0;

  // Frame-level reference model
  bit         armed;
  bit         acc_wall, acc_win;
  logic [3:0] acc_edge;
  bit         exp_cw, exp_cwin, exp_won;
  logic [3:0] exp_edge;
  int         streak;

  win_collision_detector #(.WIN_FRAMES(WF)) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .playerDrawingRequest (playerDrawingRequest),
    .playerHitEdgeCode    (playerHitEdgeCode),
    .winDrawingRequest    (winDrawingRequest),
    .wallDrawingRequest   (wallDrawingRequest),
    .clearWin             (clearWin),
    .collisionWall        (collisionWall),
    .collisionWin         (collisionWin),
    .wallEdgeCode         (wallEdgeCode),
    .gameWon              (gameWon)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    armed = 0; acc_wall = 0; acc_win = 0; acc_edge = 4'h0;
    exp_cw = 0; exp_cwin = 0; exp_won = 0; exp_edge = 4'h0; streak = 0;
  endtask

  // Drive one clock cycle (called at a falling edge, returns at the next one).
  task automatic cyc(input bit s, input bit p, input logic [3:0] e,
                     input bit w, input bit wl, input bit c);
    bit wall_ov, win_ov;
    startOfFrame = s; playerDrawingRequest = p; playerHitEdgeCode = e;
    winDrawingRequest = w; wallDrawingRequest = wl; clearWin = c;
    wall_ov = p && wl;
    win_ov  = p && w;
    exp_cw = 0; exp_cwin = 0;
    if (!armed) begin
      if (s) armed = 1;
    end else begin
      acc_wall |= wall_ov;
      acc_win  |= win_ov;
      if (wall_ov) acc_edge |= e;
      if (s) begin
        exp_cw   = acc_wall;
        exp_cwin = acc_win;
        if (acc_wall) exp_edge = acc_edge;
        streak = acc_win ? ((streak < WF) ? streak + 1 : WF) : 0;
        if (streak == WF) exp_won = 1;
        acc_wall = 0; acc_win = 0; acc_edge = 4'h0;
      end
    end
    if (c) begin
      streak = 0; exp_won = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    model_reset();
    startOfFrame = 0; playerDrawingRequest = 0; playerHitEdgeCode = 4'h0;
    winDrawingRequest = 0; wallDrawingRequest = 0; clearWin = 0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({collisionWall, collisionWin, wallEdgeCode, gameWon} !== 7'b0) begin
      fails++;
      $display("FAIL reset_values got cw=%b cwin=%b edge=%h won=%b want all 0",
               collisionWall, collisionWin, wallEdgeCode, gameWon);
    end
    resetN = 1'b1;
  endtask

  task automatic test_idle_frames();
    cyc(1, 0, 4'h0, 0, 0, 0);
    idle(4);
    cyc(1, 0, 4'h0, 0, 0, 0);
    tests++;
    if ({collisionWall, collisionWin, wallEdgeCode, gameWon} !== 7'b0) begin
      fails++;
      $display("FAIL idle_frames got cw=%b cwin=%b edge=%h won=%b want all 0",
               collisionWall, collisionWin, wallEdgeCode, gameWon);
    end
    idle(3);
  endtask

  task automatic test_wall_edges();
    cyc(0, 1, 4'h8, 0, 1, 0);
    cyc(0, 1, 4'h4, 0, 1, 0);
    cyc(0, 1, 4'h1, 0, 0, 0);
    cyc(0, 1, 4'h8, 0, 1, 0);
    idle(2);
    cyc(1, 0, 4'h0, 0, 0, 0);
    tests++;
    if (collisionWall !== 1'b1 || wallEdgeCode !== 4'hC) begin
      fails++;
      $display("FAIL wall_report got cw=%b edge=%h want cw=1 edge=c", collisionWall, wallEdgeCode);
    end
    idle(1);
    tests++;
    if (collisionWall !== 1'b0) begin
      fails++;
      $display("FAIL wall_pulse_width got cw=%b want 0", collisionWall);
    end
    idle(3);
    cyc(1, 0, 4'h0, 0, 0, 0);
    tests++;
    if (collisionWall !== 1'b0 || wallEdgeCode !== 4'hC) begin
      fails++;
      $display("FAIL edge_hold got cw=%b edge=%h want cw=0 edge=c", collisionWall, wallEdgeCode);
    end
    idle(2);
  endtask

  task automatic test_wait_sof();
    do_reset();
    cyc(0, 1, 4'h2, 0, 1, 0);
    idle(2);
    cyc(1, 1, 4'h2, 0, 1, 0);
    tests++;
    if (collisionWall !== 1'b0 || wallEdgeCode !== 4'h0) begin
      fails++;
      $display("FAIL wait_sof_ignored got cw=%b edge=%h want cw=0 edge=0", collisionWall, wallEdgeCode);
    end
    idle(2);
    cyc(0, 1, 4'h2, 0, 1, 0);
    idle(2);
    cyc(1, 0, 4'h0, 0, 0, 0);
    tests++;
    if (collisionWall !== 1'b1 || wallEdgeCode !== 4'h2) begin
      fails++;
      $display("FAIL first_real_frame got cw=%b edge=%h want cw=1 edge=2", collisionWall, wallEdgeCode);
    end
    idle(2);
  endtask

  task automatic win_frame(input bit hit);
    idle(1);
    cyc(0, 1, 4'h0, hit, 0, 0);
    idle(2);
    cyc(1, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic test_win_sequence();
    do_reset();
    cyc(1, 0, 4'h0, 0, 0, 0);
    win_frame(1);
    tests++;
    if (collisionWin !== 1'b1 || gameWon !== 1'b0) begin
      fails++;
      $display("FAIL win_frame_n got cwin=%b won=%b want cwin=1 won=0", collisionWin, gameWon);
    end
    win_frame(1);
    tests++;
    if (gameWon !== 1'b1) begin
      fails++;
      $display("FAIL win_after_two got won=%b want 1", gameWon);
    end
    do_reset();
    cyc(1, 0, 4'h0, 0, 0, 0);
    win_frame(1);
    win_frame(0);
    tests++;
    if (collisionWin !== 1'b0) begin
      fails++;
      $display("FAIL miss_frame_pulse got cwin=%b want 0", collisionWin);
    end
    win_frame(1);
    tests++;
    if (gameWon !== 1'b0) begin
      fails++;
      $display("FAIL win_miss_win got won=%b want 0", gameWon);
    end
  endtask

  task automatic test_clear_win();
    do_reset();
    cyc(1, 0, 4'h0, 0, 0, 0);
    win_frame(1);
    win_frame(1);
    idle(1);
    cyc(0, 1, 4'h0, 1, 0, 0);
    idle(2);
    cyc(1, 0, 4'h0, 0, 0, 1);
    tests++;
    if (gameWon !== 1'b0) begin
      fails++;
      $display("FAIL clear_priority got won=%b want 0", gameWon);
    end
    win_frame(1);
    tests++;
    if (gameWon !== 1'b0) begin
      fails++;
      $display("FAIL counter_cleared got won=%b want 0", gameWon);
    end
    win_frame(1);
    tests++;
    if (gameWon !== 1'b1) begin
      fails++;
      $display("FAIL win_after_clear got won=%b want 1", gameWon);
    end
  endtask

  task automatic test_sof_boundary();
    do_reset();
    cyc(1, 0, 4'h0, 0, 0, 0);
    idle(3);
    cyc(1, 1, 4'h1, 1, 1, 0);
    tests++;
    if (collisionWall !== 1'b1 || collisionWin !== 1'b1 || wallEdgeCode !== 4'h1) begin
      fails++;
      $display("FAIL overlap_on_sof got cw=%b cwin=%b edge=%h want 1 1 1",
               collisionWall, collisionWin, wallEdgeCode);
    end
    cyc(0, 1, 4'h2, 0, 1, 0);
    tests++;
    if (collisionWall !== 1'b0) begin
      fails++;
      $display("FAIL report_cycle_pulse got cw=%b want 0", collisionWall);
    end
    idle(3);
    cyc(1, 0, 4'h0, 0, 0, 0);
    tests++;
    if (collisionWall !== 1'b1 || wallEdgeCode !== 4'h2) begin
      fails++;
      $display("FAIL overlap_on_report got cw=%b edge=%h want cw=1 edge=2", collisionWall, wallEdgeCode);
    end
    idle(2);
  endtask

  task automatic test_reset_midframe();
    cyc(0, 1, 4'h4, 0, 1, 0);
    do_reset();
    cyc(1, 0, 4'h0, 0, 0, 0);
    tests++;
    if (collisionWall !== 1'b0) begin
      fails++;
      $display("FAIL midreset_first_sof got cw=%b want 0", collisionWall);
    end
    idle(3);
    cyc(1, 0, 4'h0, 0, 0, 0);
    tests++;
    if (collisionWall !== 1'b0 || wallEdgeCode !== 4'h0) begin
      fails++;
      $display("FAIL midreset_lost got cw=%b edge=%h want cw=0 edge=0", collisionWall, wallEdgeCode);
    end
    idle(2);
  endtask

  task automatic test_random();
    int pct;
    int len;
    do_reset();
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(3, 20);
      case ($urandom_range(0, 2))
        0: pct = 0;
        1: pct = 5;
        default: pct = 30;
      endcase
      for (int i = 0; i < len; i++) begin
        cyc(i == 0,
            $urandom_range(0, 99) < 50,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 99) < pct,
            $urandom_range(0, 99) < pct,
            $urandom_range(0, 99) < 3);
        tests++;
        if (collisionWall !== exp_cw || collisionWin !== exp_cwin ||
            wallEdgeCode !== exp_edge || gameWon !== exp_won) begin
          fails++;
          $display("FAIL random f=%0d c=%0d got cw=%b cwin=%b edge=%h won=%b want cw=%b cwin=%b edge=%h won=%b",
                   f, i, collisionWall, collisionWin, wallEdgeCode, gameWon,
                   exp_cw, exp_cwin, exp_edge, exp_won);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_idle_frames();
    test_wall_edges();
    test_wait_sof();
    test_win_sequence();
    test_clear_win();
    test_sof_boundary();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
